// File: rtl/rca_pkg.sv
// Shared definitions for the adder result serializer: widths, frame size,
// state encoding and the running-checksum helper.
package rca_pkg;

  localparam int RCA_WIDTH = 32;
  localparam int RCA_NDATA = RCA_WIDTH / 8 + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CHK  = 2'd2
  } state_t;

  // Fold one frame byte into the running XOR checksum.
  function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] b);
    return chk ^ b;
  endfunction

endpackage

// File: rtl/rca_result_serializer_if.sv
// Byte-wide valid/ready link carrying the serialized result frame.
interface rca_result_serializer_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;

  modport master (
    output tx_data,
    output tx_valid,
    output tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  tx_last,
    output tx_ready
  );

endinterface

// File: rtl/rca_result_serializer.sv
// Captures one {cout, sum} adder result on a strobe and streams it out
// LSB byte first over an 8-bit valid/ready link, followed by an XOR
// checksum byte flagged with tx_last. All outputs come straight from flops.
module rca_result_serializer
  import rca_pkg::*;
#(
  parameter int WIDTH = RCA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       cap_valid,
  input  logic [WIDTH-1:0]           cap_sum,
  input  logic                       cap_cout,
  rca_result_serializer_if.master    tx,
  output logic                       busy,
  output logic                       err_drop,
  input  logic                       clr_err
);

  localparam int NDATA = WIDTH / 8 + 1;
  localparam int SH_W  = NDATA * 8;
  localparam int CNT_W = (NDATA > 2) ? $clog2(NDATA) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDATA - 1);

  state_t            state_r, state_s;
  logic [SH_W-1:0]   shreg_r, shreg_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [7:0]        chk_r, chk_s;

  logic [7:0]        tx_data_r, tx_data_s;
  logic              tx_valid_r, tx_valid_s;
  logic              tx_last_r, tx_last_s;
  logic              busy_r, busy_s;
  logic              err_drop_r, err_drop_s;

  logic              xfer_s;
  logic              accept_s;
  logic              drop_s;

  // Handshake qualifiers: byte transfer, capture acceptance and lost strobes.
  always_comb begin
    xfer_s   = tx_valid_r & tx.tx_ready;
    accept_s = ena & cap_valid &
               ((state_r == IDLE) | ((state_r == CHK) & tx.tx_ready));
    drop_s   = ena & cap_valid & ~accept_s;
  end

  // Next-state, datapath and next-output computation; a held byte keeps
  // everything frozen until the sink takes it.
  always_comb begin
    state_s    = state_r;
    shreg_s    = shreg_r;
    cnt_s      = cnt_r;
    chk_s      = chk_r;
    tx_data_s  = 8'h00;
    tx_valid_s = 1'b0;
    tx_last_s  = 1'b0;
    busy_s     = 1'b0;
    err_drop_s = err_drop_r;

    case (state_r)
      IDLE: begin
        state_s = IDLE;
      end
      DATA: begin
        if (xfer_s) begin
          shreg_s = {8'h00, shreg_r[SH_W-1:8]};
          chk_s   = chk_update(chk_r, shreg_r[7:0]);
          cnt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == CNT_LAST) begin
            state_s = CHK;
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
      CHK: begin
        if (xfer_s) begin
          state_s = IDLE;
        end else begin
          state_s = CHK;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // A capture overrides the above: only legal from IDLE or on the
    // checksum transfer, which gives back-to-back frames with no bubble.
    if (accept_s) begin
      shreg_s = {7'b0000000, cap_cout, cap_sum};
      cnt_s   = {CNT_W{1'b0}};
      chk_s   = 8'h00;
      state_s = DATA;
    end else begin
      state_s = state_s;
    end

    // Outputs are a decode of the next state so they can be registered.
    case (state_s)
      DATA: begin
        tx_data_s  = shreg_s[7:0];
        tx_valid_s = 1'b1;
        tx_last_s  = 1'b0;
        busy_s     = 1'b1;
      end
      CHK: begin
        tx_data_s  = chk_s;
        tx_valid_s = 1'b1;
        tx_last_s  = 1'b1;
        busy_s     = 1'b1;
      end
      default: begin
        tx_data_s  = 8'h00;
        tx_valid_s = 1'b0;
        tx_last_s  = 1'b0;
        busy_s     = 1'b0;
      end
    endcase

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop_s) begin
      err_drop_s = 1'b1;
    end else if (clr_err) begin
      err_drop_s = 1'b0;
    end else begin
      err_drop_s = err_drop_r;
    end
  end

  // State, datapath and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      shreg_r    <= {SH_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      chk_r      <= 8'h00;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      tx_last_r  <= 1'b0;
      busy_r     <= 1'b0;
      err_drop_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      shreg_r    <= shreg_s;
      cnt_r      <= cnt_s;
      chk_r      <= chk_s;
      tx_data_r  <= tx_data_s;
      tx_valid_r <= tx_valid_s;
      tx_last_r  <= tx_last_s;
      busy_r     <= busy_s;
      err_drop_r <= err_drop_s;
    end
  end

  assign tx.tx_data  = tx_data_r;
  assign tx.tx_valid = tx_valid_r;
  assign tx.tx_last  = tx_last_r;
  assign busy        = busy_r;
  assign err_drop    = err_drop_r;

endmodule
